// File: rtl/serial_sub4.sv
`default_nettype none
// ============================================================================
//  Module   : serial_sub4
//  Purpose  : Bit-serial subtractor, d = a - b - bi, one bit per clock, LSB
//             first. It is the companion to the ripple-carry adder macro and
//             serves as a cross-check engine (s - b should give back a).
//             Operands enter through a start/ready handshake. The result is
//             held stable and is qualified by a one-cycle done pulse.
//  Revision : 1.0  initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk    in   1      rising-edge clock
//    rst_n  in   1      asynchronous active-low reset
//    start  in   1      request, sampled only while ready=1
//    a      in   WIDTH  minuend, captured on the accepting edge
//    b      in   WIDTH  subtrahend, captured on the accepting edge
//    bi     in   1      borrow in, captured on the accepting edge
//    ready  out  1      idle, able to accept start
//    busy   out  1      serial operation in progress
//    done   out  1      one-cycle pulse when d/bo are updated
//    d      out  WIDTH  (a - b - bi) mod 2^WIDTH
//    bo     out  1      borrow out, set iff a < b + bi (unsigned)
// ============================================================================
module serial_sub4 #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bi,
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] d,
  output logic             bo
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t           state_q;
  logic [WIDTH-1:0] ra_q;
  logic [WIDTH-1:0] rb_q;
  // Holds the first WIDTH-1 difference bits. The final bit is appended
  // directly when d is loaded, so no bit of this register is left unused.
  logic [WIDTH-2:0] res_q;
  logic [CNT_W-1:0] cnt_q;
  logic             borrow_q;
  logic [WIDTH-1:0] d_q;
  logic             bo_q;
  logic             ready_q;
  logic             busy_q;
  logic             done_q;

  logic             diff_bit;
  logic             borrow_d;
  logic [WIDTH-1:0] res_full;
  logic [WIDTH-2:0] res_d;

  // Full-subtractor cell operating on the current LSBs.
  assign diff_bit = ra_q[0] ^ rb_q[0] ^ borrow_q;
  assign borrow_d = (~ra_q[0] & rb_q[0]) | (~(ra_q[0] ^ rb_q[0]) & borrow_q);

  // The new bit enters at the MSB. Once WIDTH bits have been shifted in,
  // res_full holds the complete difference.
  assign res_full = {diff_bit, res_q};
  assign res_d    = res_full[WIDTH-1:1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      ra_q     <= '0;
      rb_q     <= '0;
      res_q    <= '0;
      cnt_q    <= '0;
      borrow_q <= 1'b0;
      d_q      <= '0;
      bo_q     <= 1'b0;
      ready_q  <= 1'b1;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            ra_q     <= a;
            rb_q     <= b;
            borrow_q <= bi;
            cnt_q    <= '0;
            state_q  <= S_SHIFT;
            ready_q  <= 1'b0;
            busy_q   <= 1'b1;
          end
        end

        S_SHIFT: begin
          ra_q     <= ra_q >> 1;
          rb_q     <= rb_q >> 1;
          borrow_q <= borrow_d;
          res_q    <= res_d;
          if (cnt_q == CNT_LAST) begin
            // Last bit: publish the whole word at once so that a partial
            // result never appears on d.
            d_q     <= res_full;
            bo_q    <= borrow_d;
            state_q <= S_DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end

        S_DONE: begin
          done_q  <= 1'b0;
          ready_q <= 1'b1;
          state_q <= S_IDLE;
        end

        default: begin
          state_q <= S_IDLE;
          ready_q <= 1'b1;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign ready = ready_q;
  assign busy  = busy_q;
  assign done  = done_q;
  assign d     = d_q;
  assign bo    = bo_q;

endmodule
`default_nettype wire

// File: doc/serial_sub4.md
Name: serial_sub4

Overview:
- Bit-serial subtractor computing d = a - b - bi, one bit per clock, LSB first.
- It is the inverse-direction companion to the 4-bit ripple-carry adder macro in the same datapath library.
- Used where area matters more than latency, and as a reference engine to cross-check adder results (a + b = s checked as s - b = a).
- Operands enter through a start/ready handshake; the result is held stable, qualified by a one-cycle done pulse.

Parameters:
- WIDTH, 4, operand/result width in bits (legal range 2..16).

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- start  input  1  request; sampled only while ready=1
- a  input  WIDTH  minuend, captured on the accepting edge
- b  input  WIDTH  subtrahend, captured on the accepting edge
- bi  input  1  borrow in, captured on the accepting edge
- ready  output  1  high in IDLE; start is accepted only when high
- busy  output  1  high while the serial operation is in progress (SHIFT state)
- done  output  1  one-cycle pulse when d/bo become valid
- d  output  WIDTH  difference (a - b - bi) mod 2^WIDTH
- bo  output  1  borrow out; 1 iff a < b + bi (unsigned)

Behaviour:
- Reset (async assert, sync-safe deassert):
  - state=IDLE; internal regs cleared.
  - Outputs: ready=1, busy=0, done=0, d=0, bo=0.
  - Reset mid-operation aborts the operation with no done pulse.
- States: IDLE, SHIFT, DONE (one-hot or binary, all transitions registered).
- IDLE:
  - ready=1.
  - At an edge with start=1: capture a→ra, b→rb, bi→borrow reg, cnt=0, go to SHIFT.
  - start=0: stay.
- SHIFT, each edge:
  - Form diff_bit = ra[0] ^ rb[0] ^ borrow.
  - New borrow = (~ra[0] & rb[0]) | (~(ra[0] ^ rb[0]) & borrow).
  - Shift ra and rb right by 1.
  - Shift diff_bit into the MSB of the result shift register.
  - cnt++.
  - On the edge where cnt reaches WIDTH-1 (the WIDTH-th bit): load d from the completed shift register, load bo from the final borrow, go to DONE.
- DONE: done=1 for exactly this cycle, ready=0, busy=0; next edge goes to IDLE unconditionally.
- Latency: accepting edge at cycle 0; done is high in the cycle following edge WIDTH, i.e. WIDTH+1 clocks from acceptance to the done cycle. Back-to-back throughput is one result per WIDTH+2 cycles.
- d and bo change only on the edge entering DONE; they hold until the next result, including across IDLE. Partial results are never visible on d.
- start while busy=1 or in DONE is ignored, with no queuing.
- Operand inputs are don't-care except on the accepting edge; changes during SHIFT must not affect the result.
- cnt is wide enough for WIDTH-1 (clog2) and never wraps past WIDTH-1.
- No combinational path from inputs to outputs; all outputs are registered or decoded from state only.

Test Plan:
- Reset, then 9-3, bi=0, start pulsed one cycle -> busy for 4 cycles; done high in cycle 5 after acceptance with d=4'h6, bo=0; ready returns the next cycle.
- 3-9, bi=0 -> d=4'hA, bo=1. Then 0-0, bi=1 -> d=4'hF, bo=1. Then 15-15, bi=0 -> d=0, bo=0. Run back-to-back with start held high; each done is spaced 6 cycles apart.
- Start accepted with a=5, b=2; start re-asserted and a/b/bi toggled to 15/15/1 during SHIFT -> only d=4'h3, bo=0 is produced, with a single done pulse.
- rst_n asserted low in the 2nd SHIFT cycle -> outputs go to reset values immediately, no done; a later op 7-1 yields d=4'h6, bo=0.
- Exhaustive sweep of all a, b, bi (512 ops) against the reference model a - b - bi -> every {bo,d} matches, and d is unchanged between done pulses.
- WIDTH=8: 8'h00-8'h01, bi=0 -> d=8'hFF, bo=1, with done 9 cycles after acceptance.
